// File: rtl/key_conditioner.sv
// Debounces active-low push-buttons into clean levels with press/release pulses.
// Define KEY_AUTOREPEAT_EN to build the hold counters that drive keyRepeat.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_WIDTH       = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keyN,
  output logic [NUM_KEYS-1:0] keyLevel,
  output logic [NUM_KEYS-1:0] keyPress,
  output logic [NUM_KEYS-1:0] keyRelease,
  output logic [NUM_KEYS-1:0] keyRepeat
);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DC_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Counters must be able to hold every terminal count they compare against.
  if (DEBOUNCE_CYCLES < 2 ||
      (64'd1 << CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES) ||
      (64'd1 << CNT_WIDTH) <= 64'(REPEAT_DELAY) ||
      (64'd1 << CNT_WIDTH) <= 64'(REPEAT_PERIOD)) begin : g_param_error
    $error("key_conditioner: invalid DEBOUNCE_CYCLES/CNT_WIDTH combination");
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic                 sync1_reg;
      logic                 sync2_reg;
      logic                 s;
      key_state_t           state_reg;
      key_state_t           state_next;
      logic [CNT_WIDTH-1:0] dc_reg;
      logic [CNT_WIDTH-1:0] dc_next;
      logic                 press_reg;
      logic                 press_next;
      logic                 release_reg;
      logic                 release_next;

      assign s = ~sync2_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          state_reg   <= RELEASED;
          dc_reg      <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          sync1_reg   <= keyN[gi];
          sync2_reg   <= sync1_reg;
          state_reg   <= state_next;
          dc_reg      <= dc_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      // A single cycle of agreement with the accepted level restarts the count.
      always_comb begin
        state_next   = state_reg;
        dc_next      = dc_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (s == (state_reg == PRESSED)) begin
          dc_next = '0;
        end else if (dc_reg == DC_LAST) begin
          dc_next = '0;
          if (s) begin
            state_next = PRESSED;
            press_next = 1'b1;
          end else begin
            state_next   = RELEASED;
            release_next = 1'b1;
          end
        end else begin
          dc_next = dc_reg + CNT_ONE;
        end
      end

      assign keyLevel[gi]   = (state_reg == PRESSED);
      assign keyPress[gi]   = press_reg;
      assign keyRelease[gi] = release_reg;

`ifdef KEY_AUTOREPEAT_EN
      localparam logic [CNT_WIDTH-1:0] RPT_FIRST = CNT_WIDTH'(REPEAT_DELAY - 1);
      localparam logic [CNT_WIDTH-1:0] RPT_NEXT  = CNT_WIDTH'(REPEAT_PERIOD - 1);

      logic [CNT_WIDTH-1:0] hc_reg;
      logic [CNT_WIDTH-1:0] hc_next;
      logic                 armed_reg;
      logic                 armed_next;
      logic                 repeat_reg;
      logic                 repeat_next;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          hc_reg     <= '0;
          armed_reg  <= 1'b0;
          repeat_reg <= 1'b0;
        end else begin
          hc_reg     <= hc_next;
          armed_reg  <= armed_next;
          repeat_reg <= repeat_next;
        end
      end

      // armed selects the period interval once the initial delay has elapsed;
      // entry, release and idle all clear the hold count.
      always_comb begin
        hc_next     = '0;
        armed_next  = 1'b0;
        repeat_next = 1'b0;
        if (state_reg == PRESSED && state_next == PRESSED) begin
          armed_next = armed_reg;
          if (hc_reg == (armed_reg ? RPT_NEXT : RPT_FIRST)) begin
            repeat_next = 1'b1;
            armed_next  = 1'b1;
          end else begin
            hc_next = hc_reg + CNT_ONE;
          end
        end
      end

      assign keyRepeat[gi] = repeat_reg;
`else
      assign keyRepeat[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner (DEBOUNCE=4, DELAY=20, PERIOD=8).
// Repeat expectations follow whether KEY_AUTOREPEAT_EN is defined for the build.
module tb_key_conditioner;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] keyN;
  logic [3:0] keyLevel;
  logic [3:0] keyPress;
  logic [3:0] keyRelease;
  logic [3:0] keyRepeat;

  int total = 0;
  int bad   = 0;

  key_conditioner #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_WIDTH      (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .keyN      (keyN),
    .keyLevel  (keyLevel),
    .keyPress  (keyPress),
    .keyRelease(keyRelease),
    .keyRepeat (keyRepeat)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] bit_if(input bit c, input logic [3:0] m);
    return c ? m : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input logic [3:0] l,
                         input logic [3:0] p, input logic [3:0] r, input logic [3:0] q);
    string name;
    name = $sformatf("%s@%0d", tag, t);
    chk({name, ".level"},   keyLevel,   l);
    chk({name, ".press"},   keyPress,   p);
    chk({name, ".release"}, keyRelease, r);
    chk({name, ".repeat"},  keyRepeat,  q);
    $display("step %s lvl=%b prs=%b rel=%b rpt=%b", name, keyLevel, keyPress, keyRelease, keyRepeat);
  endtask

  initial begin
    keyN  = 4'hF;
    reset = 1'b1;
    repeat (3) tick();
    chk_all("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk_all("idle", t, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Clean press on key0 held 40 cycles, then released.
    keyN = 4'b1110;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk_all("press0", t, bit_if(t >= 6, 4'h1), bit_if(t == 6, 4'h1), 4'h0,
              bit_if(RPT_ON && (t == 26 || t == 34), 4'h1));
    end
    keyN = 4'hF;
    for (int u = 1; u <= 20; u++) begin
      tick();
      chk_all("rel0", u, bit_if(u < 6, 4'h1), 4'h0, bit_if(u == 6, 4'h1),
              bit_if(RPT_ON && u == 2, 4'h1));
    end

    // Bounce on key1: two-cycle toggles never reach the debounce count.
    for (int i = 0; i < 15; i++) begin
      keyN = (i % 2 == 0) ? 4'b1101 : 4'b1111;
      tick();
      chk_all("bounce1a", i, 4'h0, 4'h0, 4'h0, 4'h0);
      tick();
      chk_all("bounce1b", i, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    keyN = 4'hF;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk_all("bounce1_idle", t, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Short hold on key2, release, then re-press: first repeat must be a full delay.
    keyN = 4'b1011;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk_all("press2", t, bit_if(t >= 6, 4'h4), bit_if(t == 6, 4'h4), 4'h0, 4'h0);
    end
    keyN = 4'hF;
    for (int u = 1; u <= 30; u++) begin
      tick();
      chk_all("rel2", u, bit_if(u < 6, 4'h4), 4'h0, bit_if(u == 6, 4'h4), 4'h0);
    end
    keyN = 4'b1011;
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk_all("repress2", t, bit_if(t >= 6, 4'h4), bit_if(t == 6, 4'h4), 4'h0,
              bit_if(RPT_ON && t == 26, 4'h4));
    end
    keyN = 4'hF;
    for (int u = 1; u <= 10; u++) begin
      tick();
      chk_all("rerel2", u, bit_if(u < 6, 4'h4), 4'h0, bit_if(u == 6, 4'h4),
              bit_if(RPT_ON && u == 4, 4'h4));
    end

    // Keys 3 and 0 fall on the same edge.
    keyN = 4'b0110;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk_all("simul", t, bit_if(t >= 6, 4'h9), bit_if(t == 6, 4'h9), 4'h0, 4'h0);
    end
    keyN = 4'hF;
    for (int u = 1; u <= 10; u++) begin
      tick();
      chk_all("simul_rel", u, bit_if(u < 6, 4'h9), 4'h0, bit_if(u == 6, 4'h9), 4'h0);
    end

    // Reset mid-hold on key0: outputs clear at once, then a full debounce on release.
    keyN = 4'b1110;
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk_all("hold0", t, bit_if(t >= 6, 4'h1), bit_if(t == 6, 4'h1), 4'h0,
              bit_if(RPT_ON && t == 26, 4'h1));
    end
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int t = 1; t <= 2; t++) begin
      tick();
      chk_all("in_reset", t, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk_all("post_reset", t, bit_if(t >= 6, 4'h1), bit_if(t == 6, 4'h1), 4'h0, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
